// File: rtl/traffic_phase_arbiter.sv
// Demand-driven intersection controller: round-robin green scheduling among NS, EW and
// a pedestrian walk phase, with minimum green, timed yellow/all-red and emergency preemption.
module traffic_phase_arbiter #(
   parameter int MIN_GREEN    = 5,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int WALK_TICKS   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic req_ns,
   input  logic req_ew,
   input  logic req_ped,
   input  logic emerg,
   output logic ns_g,
   output logic ns_y,
   output logic ns_r,
   output logic ew_g,
   output logic ew_y,
   output logic ew_r,
   output logic walk,
   output logic ped_pending
);

   typedef enum logic [2:0] {
      S_ALL_RED   = 3'd0,
      S_NS_GREEN  = 3'd1,
      S_NS_YELLOW = 3'd2,
      S_EW_GREEN  = 3'd3,
      S_EW_YELLOW = 3'd4,
      S_PED_WALK  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      P_NS  = 2'd0,
      P_EW  = 2'd1,
      P_PED = 2'd2
   } phase_t;

   localparam logic [4:0] MIN_GREEN_W    = 5'(MIN_GREEN);
   localparam logic [4:0] ALLRED_TICKS_W = 5'(ALLRED_TICKS);
   localparam logic [3:0] YELLOW_LAST    = 4'(YELLOW_TICKS - 1);
   localparam logic [3:0] WALK_LAST      = 4'(WALK_TICKS - 1);

   state_t      state;
   state_t      state_nxt;
   phase_t      last;
   phase_t      last_nxt;
   logic [3:0]  cnt;
   logic [4:0]  cnt_inc;
   logic        ped_q;
   logic [3:0]  demand;
   logic [2:0]  grant;

   // Round-robin pick: the candidate closest after lst wins; result is {found, phase}.
   function automatic logic [2:0] pick_next(input logic [1:0] lst, input logic [3:0] dem);
      logic [1:0] idx;
      pick_next = 3'b000;
      for (int i = 3; i >= 1; i--) begin
         idx = 2'((int'(lst) + i) % 3);
         if (dem[idx]) pick_next = {1'b1, idx};
      end
   endfunction

   // Counter compared as count+1 so that "at least N-1" never becomes a constant compare.
   assign cnt_inc = {1'b0, cnt} + 5'd1;
   assign demand  = {1'b0, ped_q, req_ew, req_ns};
   assign grant   = pick_next(last, demand);

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         S_ALL_RED: begin
            if (tick && !emerg && (cnt_inc >= ALLRED_TICKS_W) && grant[2]) begin
               last_nxt = phase_t'(grant[1:0]);
               case (grant[1:0])
                  P_NS:    state_nxt = S_NS_GREEN;
                  P_EW:    state_nxt = S_EW_GREEN;
                  default: state_nxt = S_PED_WALK;
               endcase
            end
         end
         S_NS_GREEN: begin
            if (emerg || (tick && (cnt_inc >= MIN_GREEN_W) && (req_ew || ped_q)))
               state_nxt = S_NS_YELLOW;
         end
         S_EW_GREEN: begin
            if (emerg || (tick && (cnt_inc >= MIN_GREEN_W) && (req_ns || ped_q)))
               state_nxt = S_EW_YELLOW;
         end
         S_NS_YELLOW, S_EW_YELLOW: begin
            if (tick && (cnt == YELLOW_LAST)) state_nxt = S_ALL_RED;
         end
         S_PED_WALK: begin
            if (emerg || (tick && (cnt == WALK_LAST))) state_nxt = S_ALL_RED;
         end
         default: state_nxt = S_ALL_RED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_ALL_RED;
         last  <= P_PED;
         cnt   <= 4'd0;
         ped_q <= 1'b0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         if (state_nxt != state)
            cnt <= 4'd0;
         else if (tick && (cnt != 4'hF))
            cnt <= cnt + 4'd1;
         // A press in the same cycle as walk entry stays latched for the next round.
         if (req_ped)
            ped_q <= 1'b1;
         else if ((state_nxt == S_PED_WALK) && (state != S_PED_WALK))
            ped_q <= 1'b0;
      end
   end

   always_comb begin
      ns_g = 1'b0;
      ns_y = 1'b0;
      ns_r = 1'b1;
      ew_g = 1'b0;
      ew_y = 1'b0;
      ew_r = 1'b1;
      walk = 1'b0;
      case (state)
         S_NS_GREEN:  begin ns_g = 1'b1; ns_r = 1'b0; end
         S_NS_YELLOW: begin ns_y = 1'b1; ns_r = 1'b0; end
         S_EW_GREEN:  begin ew_g = 1'b1; ew_r = 1'b0; end
         S_EW_YELLOW: begin ew_y = 1'b1; ew_r = 1'b0; end
         S_PED_WALK:  walk = 1'b1;
         default:     ;
      endcase
   end

   assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed table-driven bench for traffic_phase_arbiter, plus an asynchronous reset sequence.
module tb_traffic_phase_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tick = 1'b0;
   logic req_ns = 1'b0;
   logic req_ew = 1'b0;
   logic req_ped = 1'b0;
   logic emerg = 1'b0;
   logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Lamp patterns {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r,walk}
   localparam logic [6:0] L_AR  = 7'b001_001_0;
   localparam logic [6:0] L_NSG = 7'b100_001_0;
   localparam logic [6:0] L_NSY = 7'b010_001_0;
   localparam logic [6:0] L_EWG = 7'b001_100_0;
   localparam logic [6:0] L_EWY = 7'b001_010_0;
   localparam logic [6:0] L_PW  = 7'b001_001_1;

   typedef struct packed {
      logic       rst;
      logic       tk;
      logic       ns;
      logic       ew;
      logic       ped;
      logic       em;
      logic [5:0] n;
      logic [6:0] lamps;
      logic       pp;
   } vec_t;

   vec_t tbl[$];
   logic [6:0] lamps;
   assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};

   traffic_phase_arbiter dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .req_ns(req_ns), .req_ew(req_ew), .req_ped(req_ped), .emerg(emerg),
      .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
      .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
      .walk(walk), .ped_pending(ped_pending)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input bit rst, input bit tk, input bit ns, input bit ew,
                               input bit ped, input bit em, input int n,
                               input logic [6:0] l, input bit pp);
      vec_t v;
      v.rst = rst; v.tk = tk; v.ns = ns; v.ew = ew; v.ped = ped; v.em = em;
      v.n = 6'(n); v.lamps = l; v.pp = pp;
      return v;
   endfunction

   task automatic check_lamps(input string name, input logic [6:0] exp_l, input logic exp_pp);
      n_checks++;
      if (lamps !== exp_l || ped_pending !== exp_pp) begin
         n_fail++;
         $display("FAIL %s: lamps=%b ped_pending=%b, expected lamps=%b ped_pending=%b",
                  name, lamps, ped_pending, exp_l, exp_pp);
      end
   endtask

   // Conflicting greens must never appear.
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (ns_g && ew_g) begin
            n_fail++;
            $display("FAIL both_green: ns_g=%b ew_g=%b, expected not both 1", ns_g, ew_g);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Scenario: rest in red, then alternating NS/EW demand
      tbl.push_back(mk(1,0,0,0,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,0,0,0,0,20, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 5, L_NSG, 0));
      tbl.push_back(mk(0,1,1,1,0,0, 2, L_NSY, 0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 5, L_EWG, 0));
      tbl.push_back(mk(0,1,1,1,0,0, 2, L_EWY, 0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_NSG, 0));
      // Scenario: round-robin NS, EW, PED with a one-cycle button press
      tbl.push_back(mk(1,0,0,0,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_NSG, 0));
      tbl.push_back(mk(0,1,1,1,1,0, 1, L_NSG, 1));
      tbl.push_back(mk(0,1,1,1,0,0, 3, L_NSG, 1));
      tbl.push_back(mk(0,1,1,1,0,0, 2, L_NSY, 1));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_AR,  1));
      tbl.push_back(mk(0,1,1,1,0,0, 5, L_EWG, 1));
      tbl.push_back(mk(0,1,1,1,0,0, 2, L_EWY, 1));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_AR,  1));
      tbl.push_back(mk(0,1,1,1,0,0, 4, L_PW,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_NSG, 0));
      // Scenario: rest in green, then competing demand
      tbl.push_back(mk(1,0,0,0,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,0,0,0,30, L_NSG, 0));
      tbl.push_back(mk(0,1,1,1,0,0, 2, L_NSY, 0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,0, 1, L_EWG, 0));
      tbl.push_back(mk(0,0,1,1,0,0, 3, L_EWG, 0));
      // Scenario: preempted walk, then set-over-clear of the pedestrian latch
      tbl.push_back(mk(1,0,0,0,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,0,0,0,1,0, 1, L_AR,  1));
      tbl.push_back(mk(0,1,0,0,0,0, 2, L_PW,  0));
      tbl.push_back(mk(0,0,0,0,0,1, 1, L_AR,  0));
      tbl.push_back(mk(0,1,0,0,0,1, 2, L_AR,  0));
      tbl.push_back(mk(0,0,0,0,1,0, 1, L_AR,  1));
      tbl.push_back(mk(0,1,0,0,1,0, 1, L_PW,  1));
      tbl.push_back(mk(0,1,0,0,0,0, 3, L_PW,  1));
      tbl.push_back(mk(0,1,0,0,0,0, 1, L_AR,  1));
      tbl.push_back(mk(0,1,0,0,0,0, 1, L_PW,  0));
      // Scenario: emergency preempt of NS green, yellow finishes, red held
      tbl.push_back(mk(1,0,0,0,0,0, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,0,0,0, 3, L_NSG, 0));
      tbl.push_back(mk(0,0,1,0,0,1, 4, L_NSY, 0));
      tbl.push_back(mk(0,1,1,0,0,1, 1, L_NSY, 0));
      tbl.push_back(mk(0,1,1,0,0,1, 1, L_AR,  0));
      tbl.push_back(mk(0,1,1,1,0,1, 4, L_AR,  0));
      tbl.push_back(mk(0,1,0,1,0,0, 1, L_EWG, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < int'(tbl[i].n); k++) begin
            rst_n   = ~tbl[i].rst;
            tick    = tbl[i].tk;
            req_ns  = tbl[i].ns;
            req_ew  = tbl[i].ew;
            req_ped = tbl[i].ped;
            emerg   = tbl[i].em;
            @(posedge clk);
            #1;
            check_lamps($sformatf("vec%0d_cyc%0d", i, k), tbl[i].lamps, tbl[i].pp);
         end
      end

      // Asynchronous reset while in EW green: red must appear with no clock edge.
      check_lamps("pre_async_ew_green", L_EWG, 1'b0);
      tick = 1'b0;
      req_ped = 1'b1;
      @(posedge clk);
      #1;
      req_ped = 1'b0;
      check_lamps("ped_latched_in_ew", L_EWG, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_lamps("async_reset_mid_ew", L_AR, 1'b0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      tick   = 1'b1;
      req_ns = 1'b1;
      req_ew = 1'b1;
      @(posedge clk);
      #1;
      check_lamps("restart_grants_ns", L_NSG, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
